// File: rtl/golden_nonce_tx.sv
// Golden-nonce reporter: queues hasher results in a small FIFO and ships each
// one as four 8N1 UART frames, most-significant byte first.
module golden_nonce_tx #(
  parameter int unsigned CLKS_PER_BIT    = 1128,
  parameter logic [31:0] NONCE_ADJ       = 32'd0,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        TxD,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);

  localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_EARLY = 16'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;

  logic [31:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic [7:0]                 drop_q;
  logic                       empty, full, push, pop;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shift_q, shift_d;
  logic        txd_q, txd_d;
  logic [7:0]  cur_byte;

  assign empty = (count_q == '0);
  assign full  = count_q[FIFO_DEPTH_LOG2];
  assign pop   = (state_q == LOAD);
  assign push  = nonce_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= nonce - NONCE_ADJ;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      count_q <= count_q + {{FIFO_DEPTH_LOG2{1'b0}}, push}
                         - {{FIFO_DEPTH_LOG2{1'b0}}, pop};
      if (nonce_valid && full && !pop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (!empty) state_d = LOAD;
      LOAD: begin
        shift_d = mem_q[rd_ptr_q];
        byte_d  = '0;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 16'd1;
        // LOAD takes the last stop-bit cycle so consecutive nonces stay gapless.
        if (cnt_q == BIT_EARLY && byte_q == 2'd3 && !empty) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {shift_q[23:0], 8'h00};
            state_d = START;
          end else if (!empty) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_byte = shift_d[31:24];
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  assign TxD        = txd_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_full  = full;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Bench for golden_nonce_tx: two instances (adjust 0 and 66) share random stimulus
// and are compared cycle by cycle against a schedule-based line model.
module tb_golden_nonce_tx;

  localparam int C     = 4;
  localparam int FRAME = 40 * C;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, nonce_valid;
  logic [31:0] nonce;
  logic        txd0, busy0, full0, txd1, busy1, full1;
  logic [7:0]  drop0, drop1;

  always #5 clk = ~clk;

  golden_nonce_tx #(.CLKS_PER_BIT(C), .NONCE_ADJ(32'd0), .FIFO_DEPTH_LOG2(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .nonce_valid(nonce_valid), .nonce(nonce),
    .TxD(txd0), .busy(busy0), .fifo_full(full0), .drop_count(drop0));

  golden_nonce_tx #(.CLKS_PER_BIT(C), .NONCE_ADJ(32'd66), .FIFO_DEPTH_LOG2(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .nonce_valid(nonce_valid), .nonce(nonce),
    .TxD(txd1), .busy(busy1), .fifo_full(full1), .drop_count(drop1));

  // Each accepted nonce is remembered with the edge at which its start bit begins.
  typedef struct {
    int          pop;
    logic [31:0] raw;
  } ent_t;

  ent_t ents[$];
  int   last_pop;
  bit   have_last;
  int   drops;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_txd(input logic [31:0] adj);
    int o, f, s;
    logic [31:0] w;
    logic [7:0]  b;
    foreach (ents[i]) begin
      if (ents[i].pop <= cyc && cyc < ents[i].pop + FRAME) begin
        o = cyc - ents[i].pop;
        f = o / (10 * C);
        s = (o % (10 * C)) / C;
        w = ents[i].raw - adj;
        b = 8'(w >> (8 * (3 - f)));
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s - 1];
      end
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst_n, input logic v, input logic [31:0] n);
    int   occ, p;
    bit   pop_now;
    ent_t e;
    if (!rst_n) begin
      ents.delete();
      drops     = 0;
      have_last = 0;
    end else begin
      occ = 0;
      pop_now = 0;
      foreach (ents[i]) begin
        if (ents[i].pop >= cyc) occ++;
        if (ents[i].pop == cyc) pop_now = 1;
      end
      if (v) begin
        if (occ < DEPTH || pop_now) begin
          p = cyc + 2;
          if (have_last && last_pop + FRAME > p) p = last_pop + FRAME;
          e.pop = p;
          e.raw = n;
          ents.push_back(e);
          last_pop  = p;
          have_last = 1;
        end else if (drops < 255) begin
          drops++;
        end
      end
    end
    while (ents.size() > 0 && ents[0].pop + FRAME < cyc) void'(ents.pop_front());
  endtask

  function automatic bit model_full();
    int occ = 0;
    foreach (ents[i]) if (ents[i].pop > cyc) occ++;
    return occ == DEPTH;
  endfunction

  function automatic bit model_busy();
    foreach (ents[i]) if (ents[i].pop + FRAME > cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pop_next_edge();
    foreach (ents[i]) if (ents[i].pop == cyc + 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic rst_n, input logic v, input logic [31:0] n);
    reset_n     = rst_n;
    nonce_valid = v;
    nonce       = n;
    @(posedge clk);
    cyc++;
    model_edge(rst_n, v, n);
    #1;
    check("txd_adj0",  {31'b0, txd0},  {31'b0, exp_txd(32'd0)});
    check("txd_adj66", {31'b0, txd1},  {31'b0, exp_txd(32'd66)});
    check("busy",      {31'b0, busy0}, {31'b0, model_busy()});
    check("busy_b",    {31'b0, busy1}, {31'b0, model_busy()});
    check("fifo_full", {31'b0, full0}, {31'b0, model_full()});
    check("drop",      {24'b0, drop0}, drops);
    check("drop_b",    {24'b0, drop1}, drops);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, $urandom);
  endtask

  initial begin
    int e0;
    bit hit;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom);
    check("reset_txd", {31'b0, txd0}, 32'd1);

    // single nonce, also 0x10 through the adjusted instance
    step(1'b1, 1'b1, 32'h195a2c52);
    idle(FRAME + 10);
    step(1'b1, 1'b1, 32'h00000010);
    idle(FRAME + 10);

    // six back-to-back strobes: one popped, four queued, one dropped
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, $urandom);
    check("burst_drop", {24'b0, drop0}, 32'd1);
    idle(5 * FRAME + 10);

    // fill, then strobe exactly on a pop edge while full
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom);
    hit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!hit && model_full() && pop_next_edge()) begin
        hit = 1;
        step(1'b1, 1'b1, $urandom);
      end else begin
        step(1'b1, 1'b0, $urandom);
      end
    end
    check("pop_strobe_hit", {31'b0, hit}, 32'd1);
    idle(6 * FRAME);

    // reset mid byte 2 data bits with two entries queued
    e0 = cyc + 1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom);
    while (cyc < e0 + 2 + 21 * C + 2) step(1'b1, 1'b0, $urandom);
    step(1'b0, 1'b1, $urandom);
    check("abort_txd", {31'b0, txd0}, 32'd1);
    check("abort_busy", {31'b0, busy0}, 32'd0);
    idle(FRAME);
    step(1'b1, 1'b1, $urandom);
    idle(FRAME + 10);

    // hold the FIFO full with 300 strobes
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, $urandom);
    check("drop_sat", {24'b0, drop0}, 32'd255);
    idle(6 * FRAME);

    // random traffic with rare resets
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 999) != 0), ($urandom_range(0, 99) < 3), $urandom);
    idle(6 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/golden_nonce_tx.md
GOLDEN_NONCE_TX -- requirements
Module: golden_nonce_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1128, clock cycles per UART bit (130 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL provide parameter NONCE_ADJ, default 32'd0, pipeline-latency correction subtracted from each captured nonce.
REQ-003 SHALL provide parameter FIFO_DEPTH_LOG2, default 2, giving a result FIFO of 2**FIFO_DEPTH_LOG2 entries.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port nonce_valid, input, 1, one-cycle strobe from the hasher that nonce holds a golden nonce.
REQ-007 SHALL have port nonce, input, 32, raw hasher nonce, sampled only when nonce_valid=1.
REQ-008 SHALL have port TxD, output, 1, UART serial line, 8N1, idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is in flight or the FIFO is non-empty.
REQ-010 SHALL have port fifo_full, output, 1, high when all FIFO entries are occupied.
REQ-011 SHALL have port drop_count, output, 8, count of nonces discarded because the FIFO was full.

Function
REQ-012 SHALL write (nonce - NONCE_ADJ) mod 2**32 into the FIFO on every clk edge where nonce_valid=1 and the FIFO is not full.
REQ-013 SHALL discard a nonce arriving while the FIFO is full and no pop occurs that cycle, incrementing drop_count; drop_count SHALL saturate at 255.
REQ-014 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle, so that occupancy stays full and no drop is counted.
REQ-015 SHALL accept a push into an empty FIFO; the entry is visible to the transmitter on the next cycle and is not bypassed combinationally.
REQ-016 SHALL implement transmitter states IDLE, LOAD, START, DATA, STOP.
REQ-017 IDLE->LOAD when the FIFO is non-empty; LOAD pops one entry into a 32-bit shift word and clears the byte index.
REQ-018 LOAD->START unconditionally; START drives TxD=0 for exactly CLKS_PER_BIT cycles.
REQ-019 DATA SHALL drive 8 bits LSB-first, each for CLKS_PER_BIT cycles; byte order is most-significant byte first (nonce[31:24] first).
REQ-020 STOP SHALL drive TxD=1 for CLKS_PER_BIT cycles; then go to START if bytes remain, else to IDLE.
REQ-021 SHALL send back-to-back nonces with no idle bit between the last stop bit of one nonce and the start bit of the next: STOP->LOAD directly when the FIFO is non-empty.
REQ-022 SHALL emit one nonce as 4 frames totalling exactly 40*CLKS_PER_BIT cycles.
REQ-023 SHALL drive TxD low from the second clk edge after the edge sampling nonce_valid=1 when idle with an empty FIFO (2-cycle latency).
REQ-024 SHALL use a 16-bit bit-period counter and a 3-bit bit index; wrap occurs only through explicit reload, with no free-running overflow.
REQ-025 SHALL leave the FIFO contents and the in-flight frame unaffected by a change of nonce while nonce_valid=0.
REQ-026 SHALL register TxD directly from a flop, with no combinational path from any input to TxD.

Reset
REQ-027 On clk edge with reset_n=0: TxD=1, busy=0, fifo_full=0, drop_count=0, FIFO empty, state IDLE, counters 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (TxD=1 next cycle) and discard all queued nonces.
REQ-029 nonce_valid SHALL be ignored during any cycle where reset_n=0.
REQ-030 The first nonce after reset deassertion SHALL be accepted on the first edge with reset_n=1.

Verification (CLKS_PER_BIT=4, NONCE_ADJ=0 unless stated)
REQ-031 Single nonce 32'h195a2c52 -> TxD carries bytes 19,5a,2c,52 as 8N1 frames, start bit at +2 cycles, busy falls 160 cycles after TxD first goes low.
REQ-032 NONCE_ADJ=66, nonce 32'h00000010 -> transmitted word ffffffce, i.e. bytes ff,ff,ff,ce.
REQ-033 Six strobes on consecutive cycles while idle -> first popped, 4 queued, fifo_full=1, drop_count=1; five nonces sent back-to-back in 800 cycles.
REQ-034 FIFO full and strobe on the exact pop cycle -> no drop, drop_count unchanged, new nonce transmitted last.
REQ-035 reset_n=0 for 1 cycle during DATA of byte 2 with 2 entries queued -> TxD=1 next cycle, busy=0, nothing further transmitted.
REQ-036 300 nonces while FIFO is held full -> drop_count saturates at 255.
